// File: rtl/inst_fetch.sv
// Instruction fetch unit: keeps at most one instruction-memory request in
// flight and buffers up to two fetched {pc, inst} pairs for the decoder.
// A flush discards buffered and in-flight instructions and redirects fetch.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    input  logic        id_ready_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    // IDLE: no request; REQ: request whose data is kept; DROP: request whose
    // data is thrown away because a flush arrived while it was outstanding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        rd_ptr;
    logic [1:0]  count;

    logic        complete;
    logic        push;
    logic        pop;
    logic        wr_ptr;
    logic [1:0]  next_count;
    logic [31:0] flush_target;
    logic [31:0] seq_pc;

    // A flush suppresses both the push and the pop of its cycle.
    assign complete     = rom_req_o & rom_ack_i;
    assign push         = complete & (state == REQ) & ~flush_i;
    assign pop          = (count != 2'd0) & id_ready_i & ~flush_i;
    // Tail slot sits one past the head when one entry is held; push never
    // happens with two entries, so count[0] is enough to locate it.
    assign wr_ptr       = rd_ptr ^ count[0];
    assign next_count   = count + {1'b0, push} - {1'b0, pop};
    assign flush_target = {flush_pc_i[31:2], 2'b00};
    // Wraps naturally from 0xFFFFFFFC to 0x00000000.
    assign seq_pc       = rom_addr_o + 32'd4;

    // Outputs come straight from registers; no path from rom_* reaches them.
    assign inst_valid_o = (count != 2'd0);
    assign pc_o         = buf_pc[rd_ptr];
    assign inst_o       = buf_inst[rd_ptr];

    // Two-entry instruction buffer storage.
    always_ff @(posedge clk) begin
        // NOTE: the two buffer slots are reset so pc_o/inst_o read zero out of
        // reset; a larger buffer would normally be left unreset.
        if (rst) begin
            buf_pc[0]   <= 32'd0;
            buf_pc[1]   <= 32'd0;
            buf_inst[0] <= 32'd0;
            buf_inst[1] <= 32'd0;
        end else if (push) begin
            buf_pc[wr_ptr]   <= rom_addr_o;
            buf_inst[wr_ptr] <= rom_data_i;
        end
    end

    // Fetch FSM, occupancy tracking and registered request outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples the pre-edge values of its neighbours.
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= 32'd0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            rom_req_o  <= 1'b0;
            rom_addr_o <= 32'd0;
        end else if (flush_i) begin
            count    <= 2'd0;
            fetch_pc <= flush_target;
            case (state)
                IDLE: begin
                    state      <= REQ;
                    rom_req_o  <= 1'b1;
                    rom_addr_o <= flush_target;
                end
                default: begin
                    // An outstanding request is never aborted: either it ends
                    // now (restart at the target) or its data is dropped later.
                    if (complete) begin
                        state      <= REQ;
                        rom_addr_o <= flush_target;
                    end else begin
                        state <= DROP;
                    end
                end
            endcase
        end else begin
            count <= next_count;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                IDLE: begin
                    if (next_count < 2'd2) begin
                        state      <= REQ;
                        rom_req_o  <= 1'b1;
                        rom_addr_o <= fetch_pc;
                    end
                end
                REQ: begin
                    if (complete) begin
                        fetch_pc <= seq_pc;
                        if (next_count < 2'd2) begin
                            rom_addr_o <= seq_pc;
                        end else begin
                            state     <= IDLE;
                            rom_req_o <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (complete) begin
                        state      <= REQ;
                        rom_addr_o <= fetch_pc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rom_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
